pc_fetch: RTL

- PC register and instruction-fetch stage. It sits downstream of the branch-resolution unit and consumes its npc_sel plus the branch/JALR targets.
- Issues one instruction-memory request at a time and delivers {pc, inst} to decode over a valid/ready handshake.
- Discards in-flight fetches when EX redirects the PC.

---
 rtl/pc_fetch_pkg.sv | 19 +
 rtl/pc_fetch_npc_gen.sv | 18 +
 rtl/pc_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the PC/fetch stage: npc_sel codes from the branch unit,
// fetch FSM states and the default reset PC.
package pc_fetch_pkg;

    localparam logic [1:0]  NPC_SEQ  = 2'd0;
    localparam logic [1:0]  NPC_BR   = 2'd1;
    localparam logic [1:0]  NPC_JALR = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_npc_gen.sv
// Redirect decode from the branch unit: taken branch/JAL or JALR, with the
// JALR target LSB forced to zero.
module npc_gen
    import pc_fetch_pkg::*;
(
    input  logic        br_valid,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    output logic        redirect,
    output logic [31:0] target
);

    // NPC_SEQ and the reserved code both fall through as "no redirect"
    assign redirect = br_valid & ((npc_sel == NPC_BR) | (npc_sel == NPC_JALR));
    assign target   = (npc_sel == NPC_BR) ? br_target : (jalr_target & ~32'h1);

endmodule

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch; delivers {pc, inst}
// to decode and discards fetches made stale by an EX redirect.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  redir_pc;
    logic         redir_pend;
    logic         redirect;
    logic [31:0]  target;

    npc_gen u_npc_gen (
        .br_valid    (br_valid),
        .npc_sel     (npc_sel),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .redirect    (redirect),
        .target      (target)
    );

    // pc only moves outside REQ, so the request address is stable until granted
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD) & ~redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_pc   <= RESET_PC;
            redir_pend <= 1'b0;
            if_pc      <= RESET_PC;
            if_inst    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) pc <= target;
                    state <= REQ;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        if (redirect)        pc <= target;
                        else if (redir_pend) pc <= redir_pc;
                        redir_pend <= 1'b0;
                        state      <= (redirect || redir_pend) ? DROP : WAIT;
                    end else if (redirect) begin
                        // remember the target; the in-flight address must not change
                        redir_pend <= 1'b1;
                        redir_pc   <= target;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (redirect || redir_pend) begin
                            pc         <= redirect ? target : redir_pc;
                            redir_pend <= 1'b0;
                            state      <= REQ;
                        end else begin
                            if_inst <= imem_resp_data;
                            if_pc   <= pc;
                            state   <= HOLD;
                        end
                    end else if (redirect) begin
                        pc    <= target;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect)        pc    <= target;
                    if (imem_resp_valid) state <= REQ;
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (if_ready) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
